// File: rtl/fetch_branch_ctrl.sv
// Fetch/sequencing controller for the multicycle RISC core.
// Owns the PC and the instruction register and fetches over a req/ack handshake.
// Branches, BL and BX run here, with a small return-address stack (RAS).
// Every other opcode is handed to the datapath, and the controller waits for
// the datapath to report completion.
module fetch_branch_ctrl #(
  parameter int PC_W      = 8,
  parameter int INSTR_W   = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_i,
  output logic                           mem_req_o,
  output logic [PC_W-1:0]                mem_addr_o,
  input  logic                           mem_ack_i,
  input  logic [INSTR_W-1:0]             mem_rdata_i,
  output logic [INSTR_W-1:0]             ir_o,
  output logic                           exec_start_o,
  input  logic                           ex_done_i,
  input  logic                           n_i,
  input  logic                           v_i,
  input  logic                           z_i,
  output logic [PC_W-1:0]                pc_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_sp_o,
  output logic                           ras_ovf_o,
  output logic                           ras_unf_o,
  output logic                           w_o
);

  localparam int SP_W = $clog2(RAS_DEPTH + 1);
  // The stack array is sized to the full pointer range so that it can be
  // indexed directly by the occupancy count. Entries at or above RAS_DEPTH
  // are never written.
  localparam int RAS_ENTRIES = 1 << SP_W;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(RAS_DEPTH);

  localparam logic [3:0] OP_BR   = 4'b0010;
  localparam logic [3:0] OP_BX   = 4'b0100;
  localparam logic [3:0] OP_BL   = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1110;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

  state_t              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [SP_W-1:0]     ras_sp_q;
  logic                ras_ovf_q;
  logic                ras_unf_q;
  logic                mem_req_q;
  logic                exec_start_q;
  logic                w_q;
  logic [PC_W-1:0]     rasMem [RAS_ENTRIES];

  logic [3:0]          irOp;
  logic [3:0]          irCond;
  logic [PC_W-1:0]     pcPlusOne;
  logic [PC_W-1:0]     pcTarget;
  logic [PC_W-1:0]     rasTop;
  logic                rasNotFull;
  logic                rasNotEmpty;
  logic                branchTaken;

  // Only branch, BL, BX and HALT are handled internally. Everything else goes
  // to the datapath, so exec_start can be registered at the time of the fetch.
  function automatic logic isDatapathOp(input logic [3:0] op);
    return !(op == OP_BR || op == OP_BX || op == OP_BL || op == OP_HALT);
  endfunction

  assign irOp        = ir_q[15:12];
  assign irCond      = ir_q[11:8];
  assign pcPlusOne   = pc_q + PC_W'(1);
  assign pcTarget    = pcPlusOne + PC_W'($signed(ir_q[7:0]));
  assign rasNotFull  = (ras_sp_q < SP_FULL);
  assign rasNotEmpty = (ras_sp_q != '0);
  assign rasTop      = rasMem[ras_sp_q - SP_W'(1)];

  // Evaluate the branch condition from the flags presented during DECODE.
  always_comb begin
    branchTaken = 1'b0;
    case (irCond)
      4'b0000: branchTaken = 1'b1;
      4'b0001: branchTaken = z_i;
      4'b0010: branchTaken = !z_i;
      4'b0011: branchTaken = n_i ^ v_i;
      4'b0100: branchTaken = (n_i ^ v_i) | z_i;
      default: branchTaken = 1'b0;
    endcase
  end

  // Push the return address on BL when there is room. Stack contents need no reset.
  always_ff @(posedge clk) begin
    if (state_q == DECODE && irOp == OP_BL && rasNotFull) begin
      rasMem[ras_sp_q] <= pcPlusOne;
    end
  end

  // Main sequencer. All handshake and status outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      ras_sp_q     <= '0;
      ras_ovf_q    <= 1'b0;
      ras_unf_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      exec_start_q <= 1'b0;
      w_q          <= 1'b1;
    end else begin
      exec_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_i) begin
            state_q   <= FETCH;
            mem_req_q <= 1'b1;
            w_q       <= 1'b0;
          end
        end
        FETCH: begin
          if (mem_ack_i) begin
            ir_q         <= mem_rdata_i;
            mem_req_q    <= 1'b0;
            exec_start_q <= isDatapathOp(mem_rdata_i[15:12]);
            state_q      <= DECODE;
          end
        end
        DECODE: begin
          case (irOp)
            OP_BR: begin
              pc_q      <= branchTaken ? pcTarget : pcPlusOne;
              state_q   <= FETCH;
              mem_req_q <= 1'b1;
            end
            OP_BL: begin
              if (rasNotFull) begin
                ras_sp_q  <= ras_sp_q + SP_W'(1);
                pc_q      <= pcTarget;
                state_q   <= FETCH;
                mem_req_q <= 1'b1;
              end else begin
                ras_ovf_q <= 1'b1;
                state_q   <= HALT;
                w_q       <= 1'b1;
              end
            end
            OP_BX: begin
              if (rasNotEmpty) begin
                ras_sp_q  <= ras_sp_q - SP_W'(1);
                pc_q      <= rasTop;
                state_q   <= FETCH;
                mem_req_q <= 1'b1;
              end else begin
                ras_unf_q <= 1'b1;
                state_q   <= HALT;
                w_q       <= 1'b1;
              end
            end
            OP_HALT: begin
              state_q <= HALT;
              w_q     <= 1'b1;
            end
            default: begin
              state_q <= EXEC;
            end
          endcase
        end
        EXEC: begin
          if (ex_done_i) begin
            pc_q      <= pcPlusOne;
            state_q   <= FETCH;
            mem_req_q <= 1'b1;
          end
        end
        HALT: begin
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          w_q       <= 1'b1;
        end
      endcase
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = pc_q;
  assign pc_o         = pc_q;
  assign ir_o         = ir_q;
  assign exec_start_o = exec_start_q;
  assign ras_sp_o     = ras_sp_q;
  assign ras_ovf_o    = ras_ovf_q;
  assign ras_unf_o    = ras_unf_q;
  assign w_o          = w_q;

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
// Testbench for fetch_branch_ctrl. It provides a behavioural memory and a
// datapath responder, and it keeps an instruction-level reference model that
// is compared at every fetch start and at every halt.
module tb_fetch_branch_ctrl;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;
   localparam int DEPTH   = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic s = 1'b0;
   logic memAck = 1'b0;
   logic [15:0] memRdata = 16'h0;
   logic exDone = 1'b0;
   logic nFlag = 1'b0;
   logic vFlag = 1'b0;
   logic zFlag = 1'b0;

   logic memReq;
   logic [7:0] memAddr;
   logic [15:0] irOut;
   logic execStart;
   logic [7:0] pcOut;
   logic [1:0] rasSp;
   logic rasOvf;
   logic rasUnf;
   logic wOut;

   fetch_branch_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .s_i(s),
      .mem_req_o(memReq), .mem_addr_o(memAddr), .mem_ack_i(memAck), .mem_rdata_i(memRdata),
      .ir_o(irOut), .exec_start_o(execStart), .ex_done_i(exDone),
      .n_i(nFlag), .v_i(vFlag), .z_i(zFlag),
      .pc_o(pcOut), .ras_sp_o(rasSp), .ras_ovf_o(rasOvf), .ras_unf_o(rasUnf), .w_o(wOut)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   logic [15:0] mem [256];
   int ackWait = 0;
   int exDelay = 0;
   bit strayEn = 1'b0;

   logic [7:0] modelPc;
   logic [7:0] modelRas [$];
   bit modelOvf;
   bit modelUnf;
   bit modelHalted;
   int modelExecExp;

   int compared = 0;
   int mismatched = 0;

   logic [7:0] logAddr [$];
   int logSp [$];
   logic [15:0] logIr [$];
   int reqLens [$];
   int execGaps [$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic modelReset();
      modelPc = 8'h00;
      modelRas.delete();
      modelOvf = 1'b0;
      modelUnf = 1'b0;
      modelHalted = 1'b0;
      modelExecExp = 0;
   endtask

   // The architectural effect of one instruction, computed with plain integer
   // arithmetic modulo 256.
   task automatic modelStep(input logic [15:0] instr);
      int seqPc;
      int tgtPc;
      int off;
      bit taken;
      off = int'($signed(instr[7:0]));
      seqPc = (int'(modelPc) + 1) % 256;
      tgtPc = (int'(modelPc) + 1 + off + 256) % 256;
      modelExecExp = 0;
      case (instr[15:12])
         4'h2: begin
            case (instr[11:8])
               4'h0: taken = 1'b1;
               4'h1: taken = zFlag;
               4'h2: taken = !zFlag;
               4'h3: taken = nFlag ^ vFlag;
               4'h4: taken = (nFlag ^ vFlag) | zFlag;
               default: taken = 1'b0;
            endcase
            modelPc = taken ? 8'(tgtPc) : 8'(seqPc);
         end
         4'h5: begin
            if (modelRas.size() < DEPTH) begin
               modelRas.push_back(8'(seqPc));
               modelPc = 8'(tgtPc);
            end else begin
               modelOvf = 1'b1;
               modelHalted = 1'b1;
            end
         end
         4'h4: begin
            if (modelRas.size() > 0) modelPc = modelRas.pop_back();
            else begin
               modelUnf = 1'b1;
               modelHalted = 1'b1;
            end
         end
         4'hE: modelHalted = 1'b1;
         default: begin
            modelExecExp = 1;
            modelPc = 8'(seqPc);
         end
      endcase
   endtask

   // Memory: acknowledge after ackWait wait cycles, and retire the instruction
   // in the model once the DUT has sampled the acknowledge.
   initial begin
      int waitCnt;
      waitCnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            memAck = 1'b0;
            waitCnt = 0;
         end else if (memAck) begin
            modelStep(memRdata);
            memAck = 1'b0;
            waitCnt = 0;
         end else if (memReq) begin
            if (waitCnt >= ackWait) begin
               memAck = 1'b1;
               memRdata = mem[memAddr];
            end else begin
               waitCnt++;
            end
         end
      end
   end

   // Datapath: after exec_start, keep ex_done low for exDelay cycles and then
   // raise it for one cycle. Optionally inject stray ex_done pulses during fetches.
   initial begin
      int cnt;
      bit armed;
      bit hadPulse;
      cnt = 0;
      armed = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            exDone = 1'b0;
            armed = 1'b0;
            cnt = 0;
         end else begin
            hadPulse = exDone;
            exDone = 1'b0;
            if (armed) begin
               if (cnt >= exDelay) begin
                  exDone = 1'b1;
                  armed = 1'b0;
               end else begin
                  cnt++;
               end
            end else if (execStart) begin
               armed = 1'b1;
               cnt = 0;
            end else if (strayEn && memReq && !hadPulse) begin
               exDone = 1'b1;
            end
         end
      end
   end

   // Compare the DUT against the model at each fetch start and each halt entry.
   initial begin
      bit prevReq;
      bit prevW;
      bit gapRun;
      int execSeen;
      int reqCnt;
      int gapCnt;
      prevReq = 1'b0;
      prevW = 1'b1;
      gapRun = 1'b0;
      execSeen = 0;
      reqCnt = 0;
      gapCnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prevReq = 1'b0;
            prevW = 1'b1;
            execSeen = 0;
            reqCnt = 0;
            gapRun = 1'b0;
            gapCnt = 0;
         end else begin
            if (execStart) begin
               execSeen++;
               gapRun = 1'b1;
               gapCnt = 0;
            end else if (gapRun) begin
               gapCnt++;
            end
            if (memReq) reqCnt++;
            if (!memReq && prevReq) begin
               reqLens.push_back(reqCnt);
               reqCnt = 0;
            end
            if (memReq && !prevReq) begin
               checkOutput("fetch_addr", 32'(memAddr), 32'(modelPc));
               checkOutput("fetch_pc", 32'(pcOut), 32'(modelPc));
               checkOutput("fetch_ras_sp", 32'(rasSp), 32'(modelRas.size()));
               checkOutput("fetch_ovf", 32'(rasOvf), 32'(modelOvf));
               checkOutput("fetch_unf", 32'(rasUnf), 32'(modelUnf));
               checkOutput("exec_pulses", 32'(execSeen), 32'(modelExecExp));
               logAddr.push_back(memAddr);
               logSp.push_back(int'(rasSp));
               logIr.push_back(irOut);
               if (gapRun) execGaps.push_back(gapCnt);
               execSeen = 0;
               gapRun = 1'b0;
            end
            if (wOut && !prevW) begin
               checkOutput("halt_pc", 32'(pcOut), 32'(modelPc));
               checkOutput("halt_ras_sp", 32'(rasSp), 32'(modelRas.size()));
               checkOutput("halt_ovf", 32'(rasOvf), 32'(modelOvf));
               checkOutput("halt_unf", 32'(rasUnf), 32'(modelUnf));
               checkOutput("halt_expected", 32'(modelHalted), 32'd1);
               checkOutput("halt_exec_pulses", 32'(execSeen), 32'(modelExecExp));
            end
            prevReq = memReq;
            prevW = wOut;
         end
      end
   end

   task automatic clearMem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
   endtask

   task automatic clearLogs();
      logAddr.delete();
      logSp.delete();
      logIr.delete();
      reqLens.delete();
      execGaps.delete();
   endtask

   task automatic applyStimulus(input int waitCycles, input int exDly, input bit stray,
                                input bit n, input bit v, input bit z);
      @(negedge clk);
      ackWait = waitCycles;
      exDelay = exDly;
      strayEn = stray;
      nFlag = n;
      vFlag = v;
      zFlag = z;
      reset = 1'b1;
      modelReset();
      clearLogs();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      s = 1'b1;
      @(negedge clk);
      s = 1'b0;
   endtask

   task automatic waitHalt(input string name);
      for (int i = 0; i < 3000; i++) begin
         if (wOut) break;
         @(negedge clk);
      end
      checkOutput({name, "_reached_halt"}, 32'(wOut), 32'd1);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit seen;
      modelReset();
      clearMem();
      repeat (3) @(negedge clk);
      checkOutput("reset_pc", 32'(pcOut), 32'd0);
      checkOutput("reset_ir", 32'(irOut), 32'd0);
      checkOutput("reset_req", 32'(memReq), 32'd0);
      checkOutput("reset_exec", 32'(execStart), 32'd0);
      checkOutput("reset_w", 32'(wOut), 32'd1);
      checkOutput("reset_sp", 32'(rasSp), 32'd0);
      checkOutput("reset_flags", 32'({rasOvf, rasUnf}), 32'd0);

      // Test 1: three wait states before the first acknowledge, and a branch to 4.
      clearMem();
      mem[0] = 16'h2003;
      applyStimulus(3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      waitHalt("t1");
      checkOutput("t1_fetches", 32'(logAddr.size()), 32'd2);
      checkOutput("t1_req_len", 32'(reqLens[0]), 32'd4);
      checkOutput("t1_ir", 32'(logIr[1]), 32'h2003);
      checkOutput("t1_pc", 32'(logAddr[1]), 32'd4);

      // Test 2: conditional branches, a backward branch, and PC wrap-around.
      clearMem();
      mem[0] = 16'h2105;
      applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      waitHalt("t2_z0");
      checkOutput("t2_z0_pc", 32'(pcOut), 32'd1);
      applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      waitHalt("t2_z1");
      checkOutput("t2_z1_pc", 32'(pcOut), 32'd6);

      clearMem();
      mem[0] = 16'h2302;
      mem[3] = 16'h2402;
      mem[6] = 16'h2203;
      mem[10] = 16'h2105;
      mem[11] = 16'h2705;
      applyStimulus(1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      waitHalt("t2_conds");
      checkOutput("t2_conds_pc", 32'(pcOut), 32'd12);

      clearMem();
      mem[0] = 16'h5000;
      mem[1] = 16'h20FE;
      applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      waitHalt("t2_back");
      checkOutput("t2_back_addr", 32'(logAddr[2]), 32'd0);
      checkOutput("t2_back_pc", 32'(pcOut), 32'd0);
      checkOutput("t2_back_ovf", 32'(rasOvf), 32'd1);

      clearMem();
      mem[0] = 16'h20FD;
      mem[8'hFE] = 16'h0123;
      mem[8'hFF] = 16'h2002;
      applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      waitHalt("t2_wrap");
      checkOutput("t2_wrap_ff", 32'(logAddr[2]), 32'hFF);
      checkOutput("t2_wrap_pc", 32'(pcOut), 32'd2);

      // Test 3: nested BL and BX return in LIFO order.
      clearMem();
      mem[0] = 16'h200F;
      mem[8'h10] = 16'h5020;
      mem[8'h31] = 16'h5004;
      mem[8'h36] = 16'h4000;
      mem[8'h32] = 16'h4000;
      applyStimulus(2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      waitHalt("t3");
      checkOutput("t3_a2", 32'(logAddr[2]), 32'h31);
      checkOutput("t3_a3", 32'(logAddr[3]), 32'h36);
      checkOutput("t3_a4", 32'(logAddr[4]), 32'h32);
      checkOutput("t3_a5", 32'(logAddr[5]), 32'h11);
      checkOutput("t3_sp2", 32'(logSp[2]), 32'd1);
      checkOutput("t3_sp3", 32'(logSp[3]), 32'd2);
      checkOutput("t3_sp4", 32'(logSp[4]), 32'd1);
      checkOutput("t3_sp5", 32'(logSp[5]), 32'd0);

      // Test 4: RAS overflow on the third BL, then underflow on an empty stack.
      clearMem();
      mem[0] = 16'h5000;
      mem[1] = 16'h5000;
      mem[2] = 16'h5000;
      applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      waitHalt("t4_ovf");
      checkOutput("t4_ovf_flag", 32'(rasOvf), 32'd1);
      checkOutput("t4_ovf_pc", 32'(pcOut), 32'd2);
      @(negedge clk);
      s = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("t4_halt_req", 32'(memReq), 32'd0);
      checkOutput("t4_halt_w", 32'(wOut), 32'd1);
      s = 1'b0;

      clearMem();
      mem[0] = 16'h4000;
      applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      waitHalt("t4_unf");
      checkOutput("t4_unf_flag", 32'(rasUnf), 32'd1);
      checkOutput("t4_unf_pc", 32'(pcOut), 32'd0);
      // An asynchronous reset while halted clears the sticky flag immediately.
      @(negedge clk);
      #2;
      reset = 1'b1;
      modelReset();
      #1;
      checkOutput("t6_unf_cleared", 32'(rasUnf), 32'd0);

      // Test 5: datapath op with five ex_done-low cycles and stray ex_done in FETCH.
      clearMem();
      mem[0] = 16'hA0C4;
      applyStimulus(3, 5, 1'b1, 1'b0, 1'b0, 1'b0);
      waitHalt("t5");
      checkOutput("t5_gap", 32'(execGaps[0]), 32'd7);
      checkOutput("t5_pc", 32'(pcOut), 32'd1);

      // Test 6a: reset asserted during EXEC.
      clearMem();
      mem[0] = 16'h2004;
      mem[5] = 16'hA000;
      applyStimulus(0, 40, 1'b0, 1'b0, 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (execStart) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("t6_exec_seen", 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("t6_exec_pc", 32'(pcOut), 32'd5);
      #2;
      reset = 1'b1;
      modelReset();
      #1;
      checkOutput("t6_exec_rst_pc", 32'(pcOut), 32'd0);
      checkOutput("t6_exec_rst_w", 32'(wOut), 32'd1);

      // Test 6b: reset asserted during a FETCH wait, then restart from address 0.
      clearMem();
      mem[0] = 16'h2009;
      applyStimulus(20, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (memReq && memAddr == 8'd10) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("t6_fetch_seen", 32'(seen), 32'd1);
      repeat (5) @(negedge clk);
      #2;
      reset = 1'b1;
      modelReset();
      clearLogs();
      #1;
      checkOutput("t6_fetch_rst_req", 32'(memReq), 32'd0);
      checkOutput("t6_fetch_rst_pc", 32'(pcOut), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      s = 1'b1;
      @(negedge clk);
      s = 1'b0;
      waitHalt("t6_restart");
      checkOutput("t6_restart_addr", 32'(logAddr[0]), 32'd0);
      checkOutput("t6_restart_pc", 32'(pcOut), 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
